// File: rtl/chirp_coef_reader.sv
// Chirp reference ROM sequencer: reads real/imag ROMs at addresses 0..ORDER and streams
// the coefficient pairs over valid/ready through a 2-entry buffer, one read in flight at most.
module chirp_coef_reader #(
    parameter int ORDER = 60,
    parameter int DW    = 16,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_re_data,
    input  logic [DW-1:0] rom_im_data,
    output logic [DW-1:0] coef_re,
    output logic [DW-1:0] coef_im,
    output logic [AW-1:0] coef_idx,
    output logic          coef_valid,
    output logic          coef_last,
    input  logic          coef_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ORDER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          inflight_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] re0_q, re0_d, im0_q, im0_d;
    logic [DW-1:0] re1_q, re1_d, im1_q, im1_d;
    logic [AW-1:0] idx0_q, idx0_d, idx1_q, idx1_d;

    logic          pop;
    logic          push;
    logic          issue;
    logic [1:0]    credit;

    assign pop    = (cnt_q != 2'd0) && coef_ready;
    assign push   = inflight_q;
    assign credit = cnt_q + {1'b0, inflight_q};
    // A pop in this cycle frees a slot, so a read can be issued even at full credit.
    assign issue  = (state_q == S_FETCH) && ((credit < 2'd2) || pop);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        case (state_q)
            S_IDLE: begin
                addr_d      = '0;
                last_addr_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    last_addr_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the final beat transfers so DONE follows it directly.
                if (!inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_addr_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        re0_d  = re0_q;
        im0_d  = im0_q;
        idx0_d = idx0_q;
        re1_d  = re1_q;
        im1_d  = im1_q;
        idx1_d = idx1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    re0_d  = rom_re_data;
                    im0_d  = rom_im_data;
                    idx0_d = last_addr_q;
                end else begin
                    re1_d  = rom_re_data;
                    im1_d  = rom_im_data;
                    idx1_d = last_addr_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    re0_d  = re1_q;
                    im0_d  = im1_q;
                    idx0_d = idx1_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    re0_d  = rom_re_data;
                    im0_d  = rom_im_data;
                    idx0_d = last_addr_q;
                end else begin
                    re0_d  = re1_q;
                    im0_d  = im1_q;
                    idx0_d = idx1_q;
                    re1_d  = rom_re_data;
                    im1_d  = rom_im_data;
                    idx1_d = last_addr_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
            re0_q       <= '0;
            im0_q       <= '0;
            idx0_q      <= '0;
            re1_q       <= '0;
            im1_q       <= '0;
            idx1_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= issue;
            cnt_q       <= cnt_d;
            re0_q       <= re0_d;
            im0_q       <= im0_d;
            idx0_q      <= idx0_d;
            re1_q       <= re1_d;
            im1_q       <= im1_d;
            idx1_q      <= idx1_d;
        end
    end

    assign rom_en     = issue;
    assign rom_addr   = issue ? addr_q : ((state_q == S_IDLE) ? '0 : last_addr_q);
    assign coef_re    = re0_q;
    assign coef_im    = im0_q;
    assign coef_idx   = idx0_q;
    assign coef_valid = (cnt_q != 2'd0);
    assign coef_last  = coef_valid && (idx0_q == LAST_ADDR);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
